fifo_sync_param: RTL and testbench
==================================

FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits.
REQ-002 Parameter N_log, default 10, log2 of depth; depth = 2^N_log words.
REQ-003 Parameter AFULL_TH, default 2^N_log-2, almost-full threshold in words.
REQ-004 Parameter AEMPTY_TH, default 2, almost-empty threshold in words.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 i_wr_data  input  DATA_W  write data.
REQ-008 i_wr_en  input  1  write request.
REQ-009 o_full  output  1  no free slot; write ignored.
REQ-010 o_almost_full  output  1  occupancy >= AFULL_TH.
REQ-011 i_rd_en  input  1  read request.
REQ-012 o_rd_data  output  DATA_W  read data, registered.
REQ-013 o_empty  output  1  no stored word; read ignored.
REQ-014 o_almost_empty  output  1  occupancy <= AEMPTY_TH.
REQ-015 o_words  output  N_log+1  current occupancy, 0..2^N_log.
REQ-016 o_err  output  2  sticky {overflow, underflow} flags (see Configuration).

Function
REQ-017 Write accepted iff i_wr_en=1 and o_full=0 at the clock edge; word stored at write pointer, pointer +1 modulo 2^N_log.
REQ-018 Read accepted iff i_rd_en=1 and o_empty=0; o_rd_data presents the word at read pointer one cycle later, read pointer +1 modulo 2^N_log.
REQ-019 o_rd_data holds its value when no read is accepted.
REQ-020 o_words: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither; visible the cycle after the edge.
REQ-021 o_full, o_empty, o_almost_full, o_almost_empty are registered, computed from next-state occupancy, so they are consistent with o_words every cycle.
REQ-022 Full: simultaneous i_wr_en and i_rd_en -> read accepted, write rejected; occupancy becomes 2^N_log-1.
REQ-023 Empty: simultaneous i_wr_en and i_rd_en -> write accepted, read rejected; occupancy becomes 1; data readable the next cycle, no fall-through.
REQ-024 Pointers wrap from 2^N_log-1 to 0 without data loss or flag glitch.
REQ-025 Storage is a simple dual-port array (one write port, one registered read port) inferable as block RAM; contents are not reset.

Reset
REQ-026 rst_n=0 asynchronously clears both pointers and occupancy; o_words=0, o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0, o_rd_data=0, o_err=2'b00.
REQ-027 Reset asserted mid-operation discards all stored words; first read after release returns only data written after release.
REQ-028 No write or read is accepted on the first clock edge after rst_n deasserts.

Configuration
REQ-029 Macro FIFO_SYNC_ERR_EN defined: o_err[1] sets on i_wr_en=1 while o_full=1, o_err[0] sets on i_rd_en=1 while o_empty=1; both stay set until rst_n=0.
REQ-030 Macro FIFO_SYNC_ERR_EN undefined: o_err tied to 2'b00, no error logic synthesised; all other behaviour identical.

Verification (DATA_W=8, N_log=4, AFULL_TH=14, AEMPTY_TH=2)
REQ-031 Write 0x00..0x0F back-to-back -> o_full=1 after 16th edge, o_words=16, o_almost_full=1 from occupancy 14; 17th write 0xAA ignored, o_err[1]=1 when ERR_EN.
REQ-032 Read 16 times from full -> o_rd_data 0x00..0x0F in order, each one cycle after its read, o_empty=1 after 16th edge; extra read sets o_err[0]=1 when ERR_EN.
REQ-033 Simultaneous write+read at empty -> o_words=1, o_empty=0 next cycle, o_rd_data unchanged; at full -> o_words=15, o_full=0.
REQ-034 Stream 40 words with continuous write and read one cycle behind -> pointers wrap twice, all 40 words out in order, o_words stays 1.
REQ-035 Fill to 9 words, pulse rst_n low mid-cycle -> outputs reach reset values without a clock edge; write 0x5A, read -> 0x5A.

Source files
------------

// File: rtl/fifo_sync_param.sv
`timescale 1ns/1ps
// Synchronous FIFO, 2^N_log x DATA_W, simple dual-port storage with a registered read port.
// Latency: a write is readable from the next edge; o_rd_data updates one edge after an accepted read.
// Backpressure: writes are dropped while o_full, reads while o_empty; optional sticky errors under FIFO_SYNC_ERR_EN.
module fifo_sync_param #(
    parameter int DATA_W    = 8,
    parameter int N_log     = 10,
    parameter int AFULL_TH  = (1 << N_log) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_en,
    output logic              o_full,
    output logic              o_almost_full,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_empty,
    output logic              o_almost_empty,
    output logic [N_log:0]    o_words,
    output logic [1:0]        o_err
);

    localparam int             DEPTH     = 1 << N_log;
    localparam logic [N_log:0] DEPTH_V   = (N_log + 1)'(DEPTH);
    localparam logic [N_log:0] AFULL_V   = (N_log + 1)'(AFULL_TH);
    localparam logic [N_log:0] AEMPTY_V  = (N_log + 1)'(AEMPTY_TH);
    localparam logic [N_log-1:0] PTR_ONE = (N_log)'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [N_log-1:0]  wr_ptr_q, wr_ptr_d;
    logic [N_log-1:0]  rd_ptr_q, rd_ptr_d;
    logic [N_log:0]    words_q, words_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    // Held low through the first edge after reset release so nothing is accepted on it.
    logic              run_q, run_d;

    logic              wr_acc;
    logic              rd_acc;

    always_comb begin
        wr_acc = run_q & i_wr_en & ~full_q;
        rd_acc = run_q & i_rd_en & ~empty_q;
    end

    always_comb begin
        run_d     = 1'b1;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        words_d   = words_q;
        rd_data_d = rd_data_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            rd_data_d = mem[rd_ptr_q];
        end

        case ({wr_acc, rd_acc})
            2'b10:   words_d = words_q + 1'b1;
            2'b01:   words_d = words_q - 1'b1;
            default: words_d = words_q;
        endcase

        // Flags come from the next occupancy so they always agree with o_words.
        full_d   = (words_d == DEPTH_V);
        empty_d  = (words_d == '0);
        afull_d  = (words_d >= AFULL_V);
        aempty_d = (words_d <= AEMPTY_V);
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            words_q   <= '0;
            rd_data_q <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
        end else begin
            run_q     <= run_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            words_q   <= words_d;
            rd_data_q <= rd_data_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
        end
    end

`ifdef FIFO_SYNC_ERR_EN
    logic [1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (i_wr_en && full_q) begin
            err_d[1] = 1'b1;
        end
        if (i_rd_en && empty_q) begin
            err_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 2'b00;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 2'b00;
`endif

    assign o_full         = full_q;
    assign o_empty        = empty_q;
    assign o_almost_full  = afull_q;
    assign o_almost_empty = aempty_q;
    assign o_words        = words_q;
    assign o_rd_data      = rd_data_q;

`ifndef SYNTHESIS
    a_not_full_and_empty : assert property (@(posedge clk) disable iff (!rst_n) !(full_q && empty_q));
    a_words_in_range     : assert property (@(posedge clk) disable iff (!rst_n) words_q <= DEPTH_V);
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
`timescale 1ns/1ps
// Directed bench for fifo_sync_param at DATA_W=8, N_log=4, AFULL_TH=14, AEMPTY_TH=2.
module tb_fifo_sync_param;

    logic       clk;
    logic       rst_n;
    logic [7:0] i_wr_data;
    logic       i_wr_en;
    logic       i_rd_en;
    logic       o_full;
    logic       o_almost_full;
    logic [7:0] o_rd_data;
    logic       o_empty;
    logic       o_almost_empty;
    logic [4:0] o_words;
    logic [1:0] o_err;

    int checks   = 0;
    int failures = 0;

`ifdef FIFO_SYNC_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    fifo_sync_param #(
        .DATA_W    (8),
        .N_log     (4),
        .AFULL_TH  (14),
        .AEMPTY_TH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_wr_data      (i_wr_data),
        .i_wr_en        (i_wr_en),
        .o_full         (o_full),
        .o_almost_full  (o_almost_full),
        .i_rd_en        (i_rd_en),
        .o_rd_data      (o_rd_data),
        .o_empty        (o_empty),
        .o_almost_empty (o_almost_empty),
        .o_words        (o_words),
        .o_err          (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_words"},  32'(o_words), 32'd0);
        check({tag, "_empty"},  32'(o_empty), 32'd1);
        check({tag, "_aempty"}, 32'(o_almost_empty), 32'd1);
        check({tag, "_full"},   32'(o_full), 32'd0);
        check({tag, "_afull"},  32'(o_almost_full), 32'd0);
        check({tag, "_rdata"},  32'(o_rd_data), 32'd0);
        check({tag, "_err"},    32'(o_err), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        i_wr_data = 8'h00;
        i_wr_en   = 1'b0;
        i_rd_en   = 1'b0;

        #12;
        check_reset_outputs("rst");

        // First edge after release must not accept the pending write.
        #10;
        rst_n     = 1'b1;
        i_wr_en   = 1'b1;
        i_wr_data = 8'h77;
        tick();
        check("first_edge_words", 32'(o_words), 32'd0);
        check("first_edge_empty", 32'(o_empty), 32'd1);

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            i_wr_data = 8'(i);
            i_wr_en   = 1'b1;
            tick();
            check("fill_words",  32'(o_words), 32'(i + 1));
            check("fill_full",   32'(o_full), 32'((i + 1) == 16));
            check("fill_afull",  32'(o_almost_full), 32'((i + 1) >= 14));
            check("fill_empty",  32'(o_empty), 32'd0);
            check("fill_aempty", 32'(o_almost_empty), 32'((i + 1) <= 2));
        end

        i_wr_data = 8'hAA;
        tick();
        i_wr_en = 1'b0;
        check("ovf_words", 32'(o_words), 32'd16);
        check("ovf_full",  32'(o_full), 32'd1);
        check("ovf_err",   32'(o_err), ERR_EN ? 32'h2 : 32'h0);

        // Drain in order.
        for (int i = 0; i < 16; i++) begin
            i_rd_en = 1'b1;
            tick();
            check("drain_data",  32'(o_rd_data), 32'(i));
            check("drain_words", 32'(o_words), 32'(15 - i));
            check("drain_empty", 32'(o_empty), 32'(i == 15));
            check("drain_full",  32'(o_full), 32'd0);
        end

        tick();
        i_rd_en = 1'b0;
        check("udf_hold",  32'(o_rd_data), 32'h0F);
        check("udf_words", 32'(o_words), 32'd0);
        check("udf_err",   32'(o_err), ERR_EN ? 32'h3 : 32'h0);

        // Simultaneous write+read at empty: write wins, no fall-through.
        i_wr_data = 8'h3C;
        i_wr_en   = 1'b1;
        i_rd_en   = 1'b1;
        tick();
        i_rd_en = 1'b0;
        check("se_words", 32'(o_words), 32'd1);
        check("se_empty", 32'(o_empty), 32'd0);
        check("se_rdata", 32'(o_rd_data), 32'h0F);

        for (int i = 0; i < 15; i++) begin
            i_wr_data = 8'(8'h40 + i);
            tick();
        end
        check("refill_full", 32'(o_full), 32'd1);

        // Simultaneous write+read at full: read wins, 0xEE dropped.
        i_wr_data = 8'hEE;
        i_rd_en   = 1'b1;
        tick();
        i_wr_en = 1'b0;
        check("sf_words", 32'(o_words), 32'd15);
        check("sf_full",  32'(o_full), 32'd0);
        check("sf_rdata", 32'(o_rd_data), 32'h3C);

        for (int i = 0; i < 15; i++) begin
            tick();
            check("sf_drain", 32'(o_rd_data), 32'(8'h40 + i));
        end
        i_rd_en = 1'b0;
        check("sf_drain_empty", 32'(o_empty), 32'd1);

        // Streaming with read one cycle behind write; pointers wrap.
        i_wr_en   = 1'b1;
        i_wr_data = 8'h80;
        tick();
        check("strm_first_words", 32'(o_words), 32'd1);
        for (int k = 1; k < 40; k++) begin
            i_wr_data = 8'(8'h80 + k);
            i_rd_en   = 1'b1;
            tick();
            check("strm_words", 32'(o_words), 32'd1);
            check("strm_data",  32'(o_rd_data), 32'(8'h80 + k - 1));
        end
        i_wr_en = 1'b0;
        tick();
        i_rd_en = 1'b0;
        check("strm_last",  32'(o_rd_data), 32'hA7);
        check("strm_empty", 32'(o_empty), 32'd1);

        // Fill to 9, then asynchronous reset mid-cycle.
        for (int i = 0; i < 9; i++) begin
            i_wr_en   = 1'b1;
            i_wr_data = 8'(8'h10 + i);
            tick();
        end
        i_wr_en = 1'b0;
        check("nine_words", 32'(o_words), 32'd9);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_words", 32'(o_words), 32'd0);
        i_wr_en   = 1'b1;
        i_wr_data = 8'h5A;
        tick();
        i_wr_en = 1'b0;
        check("post_rst_wr_words", 32'(o_words), 32'd1);
        i_rd_en = 1'b1;
        tick();
        i_rd_en = 1'b0;
        check("post_rst_rdata", 32'(o_rd_data), 32'h5A);
        check("post_rst_empty", 32'(o_empty), 32'd1);
        tick();
        check("post_rst_hold", 32'(o_rd_data), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
